pipelined_adder_tree: RTL and testbench
=======================================

// Module: pipelined_adder_tree
// PURPOSE
//  Parametrised N-input pipelined adder tree; successor to the fixed 8-lane first adder stage.
//  Sums NUM_IN lanes of WIDTH bits via log2(NUM_IN) registered pairwise-add levels.
//  Full-precision output, no overflow loss; valid/ready handshake with global stall and flush.
//  Sits between sample/lane producers and downstream accumulators/reduction logic.
// PARAMETERS
//  WIDTH   8  lane width in bits (>=1)
//  NUM_IN  8  number of input lanes; power of two, >=2; L = log2(NUM_IN) levels
//  SIGNED  0  0: lanes unsigned, zero-extended; 1: lanes two's complement, sign-extended
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               async reset, active-high
//  flush      in   1               sync clear of all in-flight valids
//  in_valid   in   1               in_data holds a vector to sum
//  in_ready   out  1               block can accept this cycle
//  in_data    in   NUM_IN*WIDTH    lane i = in_data[i*WIDTH +: WIDTH]
//  out_valid  out  1               sum_out holds a completed sum
//  out_ready  in   1               downstream accepts sum_out
//  sum_out    out  WIDTH+L         full-precision sum of all lanes
//  busy       out  1               any level holds a valid entry
// BEHAVIOUR
//  - Architecture: level k (1..L) registers NUM_IN>>k partial sums of WIDTH+k bits plus one valid bit.
//    Level 1 adds lane pairs (2j, 2j+1) combinationally from in_data; level k adds level k-1 pairs.
//  - Operand extension each level: SIGNED=0 zero-extend by 1 bit; SIGNED=1 sign-extend by 1 bit.
//    Result exact, never wraps/saturates.
//  - Latency: vector accepted at edge t -> out_valid=1 with its sum after edge t+L-1
//    (visible during cycle after L accepting/advancing edges); throughput 1 vector/cycle.
//  - Handshake: accept = in_valid & in_ready.
//    stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
//  - Stall is global: when stall=1 every level register and valid holds; no bubble collapse.
//  - When not stalled, all levels advance each edge. Level-1 valid <= accept.
//    Bubbles (in_valid=0) propagate as valid=0.
//  - Output transfer = out_valid & out_ready. sum_out/out_valid stable while stalled.
//    Each accepted vector is output exactly once, in order.
//  - flush=1 at an edge: all valids <= 0; data regs may hold stale values.
//    Input offered that cycle is dropped; flush beats stall and accept. in_ready is not gated by flush.
//  - busy = OR of all level valids.
//  - Reset (async assert, any time incl. mid-stream): all valids 0, all data regs 0, in-flight vectors discarded.
//    Outputs during reset: out_valid=0, sum_out=0, busy=0, in_ready=1.
//  - sum_out when out_valid=0: last registered value, don't-care for consumers.
//  - Parameter checks: NUM_IN not power of two or <2, or WIDTH<1 -> elaboration error.
// TESTING (defaults unless noted)
//  1. Reset: assert rst mid-stream with 2 vectors in flight.
//     -> immediately out_valid=0, sum_out=0, busy=0, in_ready=1; no stale output after release.
//  2. Max unsigned: all lanes 8'hFF, one-cycle in_valid, out_ready=1.
//     -> out_valid after 3 edges, sum_out=11'h7F8 (2040), single cycle.
//  3. SIGNED=1: all lanes 8'h80 -> sum_out=11'h400 (-1024).
//     Lanes {7F,81,01,FF,00,00,10,F0} -> 11'h000.
//  4. Back-to-back: 4 consecutive vectors with all lanes 1,2,3,4.
//     -> sums 8,16,24,32 on 4 consecutive cycles, in order.
//  5. Backpressure: out_ready=0 for 3 cycles with out_valid=1 and in_valid held.
//     -> sum_out stable, in_ready=0, no loss/duplication after release.
//  6. flush with 2 in flight and in_valid=1 -> next cycle busy=0, out_valid never asserts for those vectors.
//     NUM_IN=16/WIDTH=12 regression: latency 4, sum_out width 16.

Source files
------------

// File: rtl/pipelined_adder_tree.sv
// Parametrised N-input pipelined adder tree: log2(NUM_IN) registered pairwise-add levels,
// full-precision result, valid/ready handshake with a global stall and a synchronous flush.
module pipelined_adder_tree #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 8,
  parameter int SIGNED = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_IN*WIDTH-1:0]           in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH+$clog2(NUM_IN)-1:0]   sum_out,
  output logic                              busy
);

  localparam int L = $clog2(NUM_IN);

  if (WIDTH < 1 || NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_param_err
    $error("pipelined_adder_tree: NUM_IN must be a power of two >= 2 and WIDTH >= 1");
  end

  logic         stall;
  logic         accept;
  logic [L-1:0] valid_vec;

  // The whole pipe freezes while the result register is held; no bubble collapsing.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign busy     = |valid_vec;

  genvar gi, gj;
  generate
    for (gi = 1; gi <= L; gi++) begin : g_lvl
      localparam int N = NUM_IN >> gi;
      localparam int W = WIDTH + gi;

      logic [2*N*(W-1)-1:0] src;
      logic                 src_valid;
      logic [N*W-1:0]       sum_next;
      logic [N*W-1:0]       data_reg;
      logic                 valid_reg;

      if (gi == 1) begin : g_first
        assign src       = in_data;
        assign src_valid = accept;
      end else begin : g_chain
        assign src       = g_lvl[gi-1].data_reg;
        assign src_valid = g_lvl[gi-1].valid_reg;
      end

      for (gj = 0; gj < N; gj++) begin : g_pair
        logic [W-2:0] op_a;
        logic [W-2:0] op_b;
        logic [W-1:0] ext_a;
        logic [W-1:0] ext_b;

        assign op_a = src[(2*gj)*(W-1) +: W-1];
        assign op_b = src[(2*gj+1)*(W-1) +: W-1];

        // One guard bit per level keeps every partial sum exact.
        if (SIGNED != 0) begin : g_sx
          assign ext_a = {op_a[W-2], op_a};
          assign ext_b = {op_b[W-2], op_b};
        end else begin : g_zx
          assign ext_a = {1'b0, op_a};
          assign ext_b = {1'b0, op_b};
        end

        assign sum_next[gj*W +: W] = ext_a + ext_b;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (!stall) begin
          data_reg  <= sum_next;
          valid_reg <= src_valid;
        end
      end

      assign valid_vec[gi-1] = valid_reg;

      if (gi == L) begin : g_out
        assign sum_out   = data_reg;
        assign out_valid = valid_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Self-checking bench for pipelined_adder_tree: three configurations, directed vectors,
// and a scoreboard that predicts every output sum from plain lane arithmetic.
module tb_pipelined_adder_tree;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  // 0: 8x8 unsigned, 1: 8x8 signed, 2: 16x12 unsigned
  logic         in_valid  [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [191:0] in_data   [3];
  logic [10:0]  sum0;
  logic [10:0]  sum1;
  logic [15:0]  sum2;
  logic [15:0]  sum_o     [3];

  always_comb begin
    sum_o[0] = {5'd0, sum0};
    sum_o[1] = {5'd0, sum1};
    sum_o[2] = sum2;
  end

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_adder_tree #(.WIDTH(8), .NUM_IN(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0][63:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum_out(sum0), .busy(busy[0]));

  pipelined_adder_tree #(.WIDTH(8), .NUM_IN(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1][63:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum_out(sum1), .busy(busy[1]));

  pipelined_adder_tree #(.WIDTH(12), .NUM_IN(16), .SIGNED(0)) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum_out(sum2), .busy(busy[2]));

  function automatic int lw(int d);  return (d == 2) ? 12 : 8;  endfunction
  function automatic int ln(int d);  return (d == 2) ? 16 : 8;  endfunction
  function automatic int sw(int d);  return (d == 2) ? 16 : 11; endfunction
  function automatic bit ls(int d);  return (d == 1);           endfunction

  function automatic logic [191:0] fill(int d, int v);
    logic [191:0] r = '0;
    logic [191:0] mask = (192'(1) << lw(d)) - 1;
    for (int i = 0; i < ln(d); i++) r |= (192'(v) & mask) << (i * lw(d));
    return r;
  endfunction

  // Sum of lanes as ordinary integers, then viewed in the output width.
  function automatic logic [15:0] model_sum(int d, logic [191:0] v);
    longint acc = 0;
    longint lane;
    logic [191:0] mask = (192'(1) << lw(d)) - 1;
    for (int i = 0; i < ln(d); i++) begin
      lane = longint'(64'((v >> (i * lw(d))) & mask));
      if (ls(d) && lane >= (longint'(1) << (lw(d) - 1))) lane -= (longint'(1) << lw(d));
      acc += lane;
    end
    return 16'(acc & ((longint'(1) << sw(d)) - 1));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {int d; logic [15:0] s;} exp_t;
  exp_t sb[$];

  function automatic int pending(int d);
    int c = 0;
    foreach (sb[i]) if (sb[i].d == d) c++;
    return c;
  endfunction

  // Inputs change at posedge+1, so the negedge view is what the next edge will act on.
  always @(negedge clk) begin : cmp
    int   idx;
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].d == d) idx = i;
        chk($sformatf("busy%0d", d), busy[d], idx >= 0);
        chk($sformatf("in_ready%0d", d), in_ready[d], !(out_valid[d] && !out_ready[d]));
        if (out_valid[d]) begin
          if (idx < 0) begin
            chk($sformatf("spurious_out_valid%0d", d), out_valid[d], 1'b0);
          end else begin
            chk($sformatf("sum%0d", d), sum_o[d], sb[idx].s);
            if (out_ready[d]) sb.delete(idx);
          end
        end
        if (flush) begin
          for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
        end else if (in_valid[d] && in_ready[d]) begin
          e.d = d;
          e.s = model_sum(d, in_data[d]);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic send_one(int d, logic [191:0] v, logic [15:0] exp, int lat);
    int cnt;
    in_data[d]  = v;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    cnt = 1;
    while (!out_valid[d] && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk($sformatf("latency%0d", d), cnt, lat);
    chk($sformatf("direct_sum%0d", d), sum_o[d], exp);
    $display("dut%0d vector %h -> sum 0x%0h after %0d edges", d, v, sum_o[d], cnt);
    @(posedge clk); #1;
    chk($sformatf("single_cycle%0d", d), out_valid[d], 1'b0);
  endtask

  int   got_s[$];
  int   got_c[$];
  int   v;
  int   stalled;
  logic acc;
  logic seen;
  logic [15:0] held;
  logic [191:0] ramp;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; in_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid[0], 1'b0);
    chk("reset_sum", sum_o[0], 16'h0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_in_ready", in_ready[0], 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    chk("model_ff", model_sum(0, fill(0, 'hFF)), 16'h07F8);
    chk("model_s80", model_sum(1, fill(1, 'h80)), 16'h0400);
    chk("model_wide", model_sum(2, fill(2, 'hFFF)), 16'hFFF0);

    // Single vectors, unsigned and signed extremes
    send_one(0, fill(0, 'hFF), 16'h07F8, 3);
    send_one(0, fill(0, 'h00), 16'h0000, 3);
    send_one(1, fill(1, 'h80), 16'h0400, 3);
    send_one(1, 192'h7F8101FF000010F0, 16'h0000, 3);
    send_one(1, fill(1, 'h7F), 16'h03F8, 3);

    // Back-to-back 1,2,3,4
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        in_data[0] = fill(0, c + 1); in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid[0]) begin
        got_s.push_back(int'(sum_o[0])); got_c.push_back(c);
      end
    end
    chk("b2b_count", got_s.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_sum%0d", i), (i < got_s.size()) ? got_s[i] : -1, 8 * (i + 1));
    chk("b2b_consecutive", (got_c.size() == 4) ? got_c[3] - got_c[0] : -1, 3);

    // Backpressure: hold out_ready low for 3 cycles of out_valid
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    v = 10;
    in_data[0] = fill(0, v);
    stalled = 0;
    held = '0;
    for (int c = 0; c < 30 && stalled < 3; c++) begin
      acc = in_ready[0];
      @(posedge clk); #1;
      if (acc) begin v++; in_data[0] = fill(0, v); end
      if (out_valid[0]) begin
        if (stalled == 0) held = sum_o[0];
        else chk("stall_sum_stable", sum_o[0], held);
        chk("stall_in_ready", in_ready[0], 1'b0);
        stalled++;
      end
    end
    chk("stall_cycles", stalled, 3);
    chk("stall_first_sum", held, 16'd80);
    out_ready[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      acc = in_ready[0];
      @(posedge clk); #1;
      if (acc) begin v++; in_data[0] = fill(0, v); end
    end
    in_valid[0] = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    chk("bp_drained", pending(0), 0);
    chk("bp_busy", busy[0], 1'b0);

    // Flush with two vectors in flight and a third offered
    in_data[0] = fill(0, 3); in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_data[0] = fill(0, 4);
    @(posedge clk); #1;
    in_data[0] = fill(0, 5); flush = 1'b1;
    chk("flush_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid[0] = 1'b0;
    chk("flush_busy", busy[0], 1'b0);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= out_valid[0]; end
    chk("flush_no_out", seen, 1'b0);

    // Asynchronous reset with two vectors in flight
    in_data[0] = fill(0, 5); in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_data[0] = fill(0, 6);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid[0], 1'b0);
    chk("rst_mid_sum", sum_o[0], 16'h0);
    chk("rst_mid_busy", busy[0], 1'b0);
    chk("rst_mid_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen |= out_valid[0]; end
    chk("rst_no_stale", seen, 1'b0);

    // Wide configuration: 16 lanes of 12 bits, four levels
    send_one(2, fill(2, 'hFFF), 16'hFFF0, 4);
    ramp = '0;
    for (int i = 0; i < 16; i++) ramp |= 192'(i) << (i * 12);
    send_one(2, ramp, 16'd120, 4);

    repeat (2) begin @(posedge clk); #1; end
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
